// File: rtl/mem_port_master_if.sv
// Client and RAM-side signal bundle for mem_port_master.
// The master modport is the port controller; the slave modport is the client/RAM side.
interface mem_port_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        input  req_valid, req_we, req_addr, req_len,
        input  wr_valid, wr_data, rd_ready, mem_dout,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
        output mem_we, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_we, req_addr, req_len,
        output wr_valid, wr_data, rd_ready, mem_dout,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_port_master.sv
// Burst initiator for a single-port synchronous RAM: streams write beats in one per
// cycle and read beats out one per three cycles with valid/ready backpressure.
module mem_port_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_master_if.master   bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_CAP   = 3'd3;
    localparam logic [2:0] ST_RD_RESP  = 3'd4;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] cur_addr_nxt_s;
    logic [LEN_W-1:0]  beats_r;
    logic [LEN_W-1:0]  beats_nxt_s;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_last_r;

    logic              req_ready_s;
    logic              wr_ready_s;
    logic              rd_valid_s;
    logic              busy_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_din_s;

    // Next-state, address and beat-count sequencing.
    always_comb begin
        state_nxt_s    = state_r;
        cur_addr_nxt_s = cur_addr_r;
        beats_nxt_s    = beats_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    cur_addr_nxt_s = bus.req_addr;
                    beats_nxt_s    = bus.req_len;
                    state_nxt_s    = bus.req_we ? ST_WRITE : ST_RD_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (bus.wr_valid) begin
                    // Address arithmetic wraps naturally at ADDR_W bits.
                    cur_addr_nxt_s = cur_addr_r + ADDR_W'(1);
                    beats_nxt_s    = beats_r - LEN_W'(1);
                    if (beats_r == {LEN_W{1'b0}}) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_RD_ISSUE: begin
                state_nxt_s = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                state_nxt_s = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (bus.rd_ready) begin
                    if (rd_last_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cur_addr_nxt_s = cur_addr_r + ADDR_W'(1);
                        beats_nxt_s    = beats_r - LEN_W'(1);
                        state_nxt_s    = ST_RD_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_RD_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, address and beat-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cur_addr_r <= {ADDR_W{1'b0}};
            beats_r    <= {LEN_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            cur_addr_r <= cur_addr_nxt_s;
            beats_r    <= beats_nxt_s;
        end
    end

    // Read capture: RAM output is valid in RD_CAP, one edge after the RD_ISSUE address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {DATA_W{1'b0}};
            rd_last_r <= 1'b0;
        end else if (state_r == ST_RD_CAP) begin
            rd_data_r <= bus.mem_dout;
            rd_last_r <= (beats_r == {LEN_W{1'b0}});
        end else begin
            rd_data_r <= rd_data_r;
            rd_last_r <= rd_last_r;
        end
    end

    // Handshake and RAM strobe decode; mem_we follows wr_valid within the WRITE cycle.
    always_comb begin
        req_ready_s = 1'b0;
        wr_ready_s  = 1'b0;
        rd_valid_s  = 1'b0;
        mem_we_s    = 1'b0;
        mem_din_s   = {DATA_W{1'b0}};
        busy_s      = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
            end
            ST_WRITE: begin
                wr_ready_s = 1'b1;
                mem_we_s   = bus.wr_valid;
                mem_din_s  = bus.wr_data;
            end
            ST_RD_RESP: begin
                rd_valid_s = 1'b1;
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = req_ready_s;
    assign bus.wr_ready  = wr_ready_s;
    assign bus.rd_valid  = rd_valid_s;
    assign bus.rd_data   = rd_data_r;
    assign bus.rd_last   = rd_last_r;
    assign bus.busy      = busy_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = cur_addr_r;
    assign bus.mem_din   = mem_din_s;

endmodule
